bus_src_mux_pipe: RTL and testbench

Parametrised, pipelined successor to the datapath B-bus source multiplexer. It selects one of NUM_SRC register sources onto a DATA_W-bit bus. Selection is under a valid/ready handshake with a registered output and a one-entry skid buffer, so the ALU side can stall without losing transfers. Invalid selects are handled deterministically, by hold or zero, and are flagged and counted for debug.

---
 rtl/bus_src_mux_pipe.sv | 97 +++++++++
 tb/tb_bus_src_mux_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_src_mux_pipe.sv
// B-bus source multiplexer with valid/ready handshake, a registered output
// stage and a one-entry skid buffer. Invalid selects still produce a beat
// (last good value or zero), pulse sel_err and bump a saturating counter.
module bus_src_mux_pipe #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned NUM_SRC         = 20,
  parameter int unsigned SEL_W           = 5,
  parameter bit          HOLD_ON_INVALID = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SEL_W-1:0]          req_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      sel_err,
  output logic [7:0]                err_count
);

  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] last_good;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] beat;
  logic              sel_ok;
  logic              accept;
  logic              out_free;

  // Ready depends only on stored state, never on bus_ready.
  assign req_ready = !skid_full;
  assign accept    = req_valid && req_ready;
  assign out_free  = !bus_valid || bus_ready;
  assign sel_ok    = (32'(req_sel) < NUM_SRC);

  // Source mux; indices beyond NUM_SRC read as zero and are replaced below.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_sel == SEL_W'(i)) sel_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  // Beat value for this accept, including the invalid-select substitution.
  always_comb begin
    beat = sel_data;
    if (!sel_ok) beat = HOLD_ON_INVALID ? last_good : '0;
  end

  // Output register and skid buffer; skid always drains ahead of new accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_out   <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (out_free) begin
      if (skid_full) begin
        bus_valid <= 1'b1;
        bus_out   <= skid_data;
        skid_full <= accept;
        if (accept) skid_data <= beat;
      end else if (accept) begin
        bus_valid <= 1'b1;
        bus_out   <= beat;
      end else begin
        bus_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_full <= 1'b1;
      skid_data <= beat;
    end
  end

  // Last good value follows accepted valid selects in acceptance order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_good <= '0;
    end else if (accept && sel_ok) begin
      last_good <= sel_data;
    end
  end

  // Error pulse and saturating counter, driven by the accept event only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      sel_err <= accept && !sel_ok;
      if (accept && !sel_ok && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_src_mux_pipe.sv
// Randomised plus directed bench for bus_src_mux_pipe. Two instances (hold
// and zero on invalid) share stimulus; the reference treats the pipeline as a
// two-deep ordered beat queue.
module tb_bus_src_mux_pipe;

  localparam int NSRC = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic [4:0]        req_sel;
  logic [NSRC*32-1:0] src_data;
  logic              bus_ready;

  logic        rr_h, bv_h, se_h, rr_z, bv_z, se_z;
  logic [31:0] bo_h, bo_z;
  logic [7:0]  ec_h, ec_z;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] qh[$];
  logic [31:0] qz[$];
  logic [31:0] lo_h, lo_z, lg_h, lg_z;
  logic        err_exp;
  int          ecnt_exp;

  always #5 clk = ~clk;

  bus_src_mux_pipe #(.DATA_W(32), .NUM_SRC(NSRC), .SEL_W(5), .HOLD_ON_INVALID(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_h), .req_sel(req_sel),
    .src_data(src_data), .bus_valid(bv_h), .bus_ready(bus_ready), .bus_out(bo_h),
    .sel_err(se_h), .err_count(ec_h));

  bus_src_mux_pipe #(.DATA_W(32), .NUM_SRC(NSRC), .SEL_W(5), .HOLD_ON_INVALID(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_z), .req_sel(req_sel),
    .src_data(src_data), .bus_valid(bv_z), .bus_ready(bus_ready), .bus_out(bo_z),
    .sel_err(se_z), .err_count(ec_z));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    qh.delete(); qz.delete();
    lo_h = '0; lo_z = '0; lg_h = '0; lg_z = '0;
    err_exp = 1'b0; ecnt_exp = 0;
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    src_data[k*32 +: 32] = v;
  endtask

  // Check outputs at negedge, then advance one posedge and update the model.
  task automatic cycle();
    logic        comp, acc, ok;
    logic [31:0] w;
    @(negedge clk);
    check_eq("bv_h", 32'(bv_h), 32'(qh.size() > 0));
    check_eq("bv_z", 32'(bv_z), 32'(qz.size() > 0));
    check_eq("rr_h", 32'(rr_h), 32'(qh.size() < 2));
    check_eq("rr_z", 32'(rr_z), 32'(qz.size() < 2));
    check_eq("bo_h", bo_h, (qh.size() > 0) ? qh[0] : lo_h);
    check_eq("bo_z", bo_z, (qz.size() > 0) ? qz[0] : lo_z);
    check_eq("se_h", 32'(se_h), 32'(err_exp));
    check_eq("se_z", 32'(se_z), 32'(err_exp));
    check_eq("ec_h", 32'(ec_h), 32'(ecnt_exp));
    check_eq("ec_z", 32'(ec_z), 32'(ecnt_exp));
    comp = (qh.size() > 0) && bus_ready;
    acc  = req_valid && (qh.size() < 2);
    ok   = (int'(req_sel) < NSRC);
    w    = ok ? src_data[int'(req_sel)*32 +: 32] : 32'h0;
    @(posedge clk);
    if (comp) begin
      lo_h = qh.pop_front();
      lo_z = qz.pop_front();
    end
    if (acc) begin
      qh.push_back(ok ? w : lg_h);
      qz.push_back(ok ? w : 32'h0);
      if (ok) begin
        lg_h = w; lg_z = w;
      end else if (ecnt_exp < 255) begin
        ecnt_exp++;
      end
    end
    err_exp = acc && !ok;
    #1;
  endtask

  // Asynchronous reset asserted between edges; both DUTs must clear at once.
  task automatic do_reset();
    req_valid = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #2;
    check_eq("rst_bv", 32'({bv_h, bv_z}), 32'h0);
    check_eq("rst_rr", 32'({rr_h, rr_z}), 32'h3);
    check_eq("rst_bo", bo_h | bo_z, 32'h0);
    check_eq("rst_ec", 32'({ec_h, ec_z, se_h, se_z}), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [4:0] s);
    req_valid = 1'b1;
    req_sel   = s;
    cycle();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_sel = '0;
    bus_ready = 1'b1;
    for (int k = 0; k < NSRC; k++) set_src(k, 32'h1000_0000 + 32'(k));
    model_clear();
    do_reset();

    // Back-to-back accepts with consumer always ready
    req_valid = 1'b1;
    req_sel = 5'd3; cycle();
    req_sel = 5'd4; cycle();
    req_sel = 5'd5; cycle();
    req_valid = 1'b0;
    cycle(); cycle();

    // Stall: fill output and skid, then drain
    bus_ready = 1'b0;
    accept(5'd2);
    accept(5'd7);
    cycle();
    check_eq("stall_rr", 32'(rr_h), 32'h0);
    check_eq("stall_bo", bo_h, 32'h1000_0002);
    bus_ready = 1'b1;
    cycle(); cycle(); cycle();
    check_eq("drain_rr", 32'(rr_h), 32'h1);

    // Invalid select with hold: second beat repeats the first
    accept(5'd6);
    accept(5'd25);
    check_eq("hold_bo", bo_h, 32'h1000_0006);
    check_eq("zero_bo", bo_z, 32'h0);
    cycle(); cycle();
    check_eq("t3_ec", 32'(ec_h), 32'h1);

    // Invalid right after reset, then saturation
    do_reset();
    accept(5'd31);
    check_eq("inv0_bo", bo_h | bo_z, 32'h0);
    cycle();
    check_eq("inv0_ec", 32'(ec_z), 32'h1);
    req_valid = 1'b1;
    req_sel = 5'd20;
    for (int n = 0; n < 299; n++) cycle();
    req_valid = 1'b0;
    cycle(); cycle();
    check_eq("sat_ec", 32'(ec_z), 32'd255);

    // Data sampled at accept, not at delivery
    set_src(1, 32'hAAAA_AAAA);
    bus_ready = 1'b0;
    accept(5'd1);
    set_src(1, 32'h5555_5555);
    cycle(); cycle(); cycle();
    check_eq("samp_bo", bo_h, 32'hAAAA_AAAA);
    bus_ready = 1'b1;
    cycle(); cycle();
    set_src(1, 32'h1000_0001);

    // Reset with skid full discards both beats
    bus_ready = 1'b0;
    accept(5'd8);
    accept(5'd9);
    cycle();
    do_reset();
    bus_ready = 1'b1;
    cycle(); cycle(); cycle();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_sel   = 5'($urandom_range(0, 23));
      if ($urandom_range(0, 15) == 0) req_sel = 5'($urandom_range(20, 31));
      bus_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) set_src($urandom_range(0, NSRC - 1), $urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end
    req_valid = 1'b0;
    bus_ready = 1'b1;
    cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
